sprite_blitter: RTL

Parametrised sprite drawer for the asteroids frame pipeline. It takes a screen position, frame index and flip mode, then walks a sprite ROM holding NUM_FRAMES frames of SPRITE_W x SPRITE_H pixels. It emits one VGA-adapter pixel write per opaque, on-screen sprite pixel. It sits between the object FSMs (asteroids, ship, bullets) and the VGA adapter write port. It replaces the fixed 32x32 single-frame drawer: it adds selectable frames, flips, transparency, screen clipping, a start/busy/done handshake and configurable ROM latency.

---
 rtl/sprite_pkg.sv | 21 ++
 rtl/sprite_addr_gen.sv | 75 +++++++
 rtl/sprite_blitter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared constants, state encoding and width helper for the sprite blitter.
package sprite_pkg;

  localparam int DEF_COLOR_W     = 3;
  localparam int DEF_TRANSPARENT = 0;
  localparam int DEF_SCREEN_W    = 640;
  localparam int DEF_SCREEN_H    = 480;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Never returns zero so single-entry ranges still get a 1-bit field.
  function automatic int clog2(input int unsigned v);
    return (v <= 32'd1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// Column/row walker: latches the draw request, applies flips and produces
// the ROM address plus unclipped screen coordinates for the current pixel.
module sprite_addr_gen
  import sprite_pkg::*;
#(
  parameter int SPRITE_W   = 32,
  parameter int SPRITE_H   = 32,
  parameter int NUM_FRAMES = 8,
  parameter int COORD_W    = 10,
  localparam int FRM_W     = clog2(NUM_FRAMES),
  localparam int ADDR_W    = clog2(NUM_FRAMES * SPRITE_W * SPRITE_H)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [COORD_W-1:0] x_pos,
  input  logic [COORD_W-1:0] y_pos,
  input  logic [FRM_W-1:0]   frame_sel,
  input  logic               flip_x,
  input  logic               flip_y,
  output logic [ADDR_W-1:0]  addr,
  output logic [COORD_W:0]   sx,
  output logic [COORD_W:0]   sy,
  output logic               last
);

  localparam int CW       = clog2(SPRITE_W);
  localparam int RW       = clog2(SPRITE_H);
  localparam int FRAME_SZ = SPRITE_W * SPRITE_H;

  logic [CW-1:0]      col, src_col;
  logic [RW-1:0]      row, src_row;
  logic [COORD_W-1:0] base_x, base_y;
  logic [FRM_W-1:0]   frame;
  logic               fx, fy;

  always_ff @(posedge clk) begin
    if (reset) begin
      col    <= '0;
      row    <= '0;
      base_x <= '0;
      base_y <= '0;
      frame  <= '0;
      fx     <= 1'b0;
      fy     <= 1'b0;
    end else if (load) begin
      col    <= '0;
      row    <= '0;
      base_x <= x_pos;
      base_y <= y_pos;
      frame  <= (int'(frame_sel) > NUM_FRAMES - 1) ? FRM_W'(NUM_FRAMES - 1) : frame_sel;
      fx     <= flip_x;
      fy     <= flip_y;
    end else if (step) begin
      if (col == CW'(SPRITE_W - 1)) begin
        col <= '0;
        row <= last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_comb begin
    src_col = fx ? CW'(SPRITE_W - 1) - col : col;
    src_row = fy ? RW'(SPRITE_H - 1) - row : row;
    addr    = ADDR_W'(int'(frame) * FRAME_SZ + int'(src_row) * SPRITE_W + int'(src_col));
    // One extra bit so off-screen positions clip instead of wrapping to column 0.
    sx      = (COORD_W + 1)'(base_x) + (COORD_W + 1)'(col);
    sy      = (COORD_W + 1)'(base_y) + (COORD_W + 1)'(row);
    last    = (col == CW'(SPRITE_W - 1)) && (row == RW'(SPRITE_H - 1));
  end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite drawer: scans one ROM frame, carries screen coordinates alongside
// the ROM read and emits a pixel write for each opaque, on-screen pixel.
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int SPRITE_W    = 32,
  parameter int SPRITE_H    = 32,
  parameter int NUM_FRAMES  = 8,
  parameter int COORD_W     = 10,
  parameter int COLOR_W     = DEF_COLOR_W,
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter logic [COLOR_W-1:0] TRANSPARENT = COLOR_W'(DEF_TRANSPARENT),
  parameter int ROM_LATENCY = 1,
  localparam int FRM_W      = clog2(NUM_FRAMES),
  localparam int ADDR_W     = clog2(NUM_FRAMES * SPRITE_W * SPRITE_H)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COORD_W-1:0] x_pos,
  input  logic [COORD_W-1:0] y_pos,
  input  logic [FRM_W-1:0]   frame_sel,
  input  logic               flip_x,
  input  logic               flip_y,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [COLOR_W-1:0] rom_data,
  output logic               plot,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [COLOR_W-1:0] color
);

  localparam int L = ROM_LATENCY;

  state_t                state, nxt;
  logic [1:0]            drain_cnt;
  logic                  load, step, last, hit;
  logic [COORD_W:0]      sx, sy;
  logic [L:0]            vld_pipe;
  logic [L:1][COORD_W:0] sx_pipe, sy_pipe;
  logic [COORD_W-1:0]    x_hold, y_hold;
  logic [COLOR_W-1:0]    c_hold;

  sprite_addr_gen #(
    .SPRITE_W   (SPRITE_W),
    .SPRITE_H   (SPRITE_H),
    .NUM_FRAMES (NUM_FRAMES),
    .COORD_W    (COORD_W)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .step      (step),
    .x_pos     (x_pos),
    .y_pos     (y_pos),
    .frame_sel (frame_sel),
    .flip_x    (flip_x),
    .flip_y    (flip_y),
    .addr      (rom_addr),
    .sx        (sx),
    .sy        (sy),
    .last      (last)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  if (start) nxt = ST_SCAN;
      ST_SCAN:  if (last) nxt = ST_DRAIN;
      ST_DRAIN: if (drain_cnt == 2'(L - 1)) nxt = ST_DONE;
      ST_DONE:  nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_SCAN) || (state == ST_DRAIN);
    done = (state == ST_DONE);
    load = (state == ST_IDLE) && start;
    step = (state == ST_SCAN);
  end

  always_ff @(posedge clk) begin
    if (reset || state != ST_DRAIN) drain_cnt <= '0;
    else                            drain_cnt <= drain_cnt + 2'd1;
  end

  // Stage 0 marks the cycle an address is on rom_addr; stage L lines up with rom_data.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      sx_pipe  <= '0;
      sy_pipe  <= '0;
    end else begin
      vld_pipe   <= {vld_pipe[L-1:0], nxt == ST_SCAN};
      sx_pipe[1] <= sx;
      sy_pipe[1] <= sy;
      for (int i = L; i > 1; i--) begin
        sx_pipe[i] <= sx_pipe[i-1];
        sy_pipe[i] <= sy_pipe[i-1];
      end
    end
  end

  always_comb begin
    hit = vld_pipe[L] && (rom_data != TRANSPARENT) &&
          (int'(sx_pipe[L]) < SCREEN_W) && (int'(sy_pipe[L]) < SCREEN_H);
    plot  = hit;
    x     = hit ? sx_pipe[L][COORD_W-1:0] : x_hold;
    y     = hit ? sy_pipe[L][COORD_W-1:0] : y_hold;
    color = hit ? rom_data : c_hold;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_hold <= '0;
      y_hold <= '0;
      c_hold <= '0;
    end else if (hit) begin
      x_hold <= sx_pipe[L][COORD_W-1:0];
      y_hold <= sy_pipe[L][COORD_W-1:0];
      c_hold <= rom_data;
    end
  end

endmodule
